// File: rtl/rot_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : rot_share_arbiter_pkg
// Brief  : Shared widths and direction encodings for the shared byte rotator.
// Rev    : 1.0  initial release
// ============================================================================
package rot_share_arbiter_pkg;

  localparam int   ROT_W     = 8;     // rotated datum width
  localparam int   AMT_W     = 3;     // rotate amount width (0..7)
  localparam logic DIR_RIGHT = 1'b0;  // rotate toward bit 0
  localparam logic DIR_LEFT  = 1'b1;  // rotate toward bit 7

endpackage : rot_share_arbiter_pkg
`default_nettype wire

// File: rtl/rot_share_arbiter_rot8_core.sv
`default_nettype none
// ============================================================================
// Module : rot8_core
// Brief  : Combinational 8-bit barrel rotator, log-depth stages of 1/2/4.
//          Left rotation is mapped onto right rotation by negating the
//          amount modulo 8 ahead of the stages.
// Rev    : 1.0  initial release
// ============================================================================
module rot8_core
  import rot_share_arbiter_pkg::*;
(
  input  logic [ROT_W-1:0] d,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [ROT_W-1:0] q
);

  logic [AMT_W-1:0] w_amt_eff;
  logic [ROT_W-1:0] w_s1;
  logic [ROT_W-1:0] w_s2;

  // Normalise to a right rotate, then apply the 1/2/4 stages in turn.
  always_comb begin
    w_amt_eff = (dir == DIR_LEFT) ? ('0 - amt) : amt;
    w_s1      = w_amt_eff[0] ? {d[0],      d[ROT_W-1:1]}    : d;
    w_s2      = w_amt_eff[1] ? {w_s1[1:0], w_s1[ROT_W-1:2]} : w_s1;
    q         = w_amt_eff[2] ? {w_s2[3:0], w_s2[ROT_W-1:4]} : w_s2;
  end

endmodule : rot8_core
`default_nettype wire

// File: rtl/rot_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rot_share_arbiter
// Brief  : Round-robin arbiter sharing one byte rotator among NREQ clients,
//          with a one-entry valid/ready output register that drains and
//          refills in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module rot_share_arbiter
  import rot_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [ROT_W*NREQ-1:0] req_data,
  input  logic [AMT_W*NREQ-1:0] req_amt,
  input  logic [NREQ-1:0]       req_dir,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [ROT_W-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready
);

  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [ROT_W-1:0] out_data_q,  out_data_d;
  logic [IDW-1:0]   out_id_q,    out_id_d;

  logic             w_can_accept;
  logic             w_win_found;
  logic [IDW-1:0]   w_win_idx;
  logic [IDW:0]     w_cand;
  logic             w_accept;
  logic [ROT_W-1:0] w_sel_data;
  logic [AMT_W-1:0] w_sel_amt;
  logic             w_sel_dir;
  logic [ROT_W-1:0] w_rot_q;

  // Priority scan starting at rr_ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ)) begin
        w_cand = w_cand - (IDW+1)'(NREQ);
      end
      if (!w_win_found && req_valid[w_cand[IDW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[IDW-1:0];
      end
    end
  end

  // One-hot grant; held low in reset and while the output register stalls.
  always_comb begin
    w_can_accept = ~out_valid_q | out_ready;
    w_accept     = rst_n & w_can_accept & w_win_found;
    req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept & (w_win_idx == IDW'(i));
    end
  end

  // Steer the winner's operands into the shared rotator.
  always_comb begin
    w_sel_data = '0;
    w_sel_amt  = '0;
    w_sel_dir  = DIR_RIGHT;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == IDW'(i)) begin
        w_sel_data = req_data[ROT_W*i +: ROT_W];
        w_sel_amt  = req_amt[AMT_W*i +: AMT_W];
        w_sel_dir  = req_dir[i];
      end
    end
  end

  rot8_core u_rot8_core (
    .d   (w_sel_data),
    .amt (w_sel_amt),
    .dir (w_sel_dir),
    .q   (w_rot_q)
  );

  // Next-state: load on accept, clear valid on a pure drain, otherwise hold.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = w_rot_q;
      out_id_d    = w_win_idx;
      rr_ptr_d    = (w_win_idx == IDW'(NREQ-1)) ? '0 : w_win_idx + IDW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule : rot_share_arbiter
`default_nettype wire

// File: tb/tb_rot_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rot_share_arbiter
// Brief  : Scoreboard bench for rot_share_arbiter with directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rot_share_arbiter;
  import rot_share_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [ROT_W*NREQ-1:0] req_data;
  logic [AMT_W*NREQ-1:0] req_amt;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [ROT_W-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  int checks = 0;
  int errors = 0;
  logic [IDW+ROT_W-1:0] exp_q[$];

  // Per-requester table for the multi-requester phases, expected by hand:
  // 81 R1 -> C0, 0F L2 -> 3C, F0 R5 -> 87, 5A L6 -> 96.
  logic [7:0] tbl_d [NREQ] = '{8'h81, 8'h0F, 8'hF0, 8'h5A};
  logic [2:0] tbl_a [NREQ] = '{3'd1, 3'd2, 3'd5, 3'd6};
  logic       tbl_r [NREQ] = '{DIR_RIGHT, DIR_LEFT, DIR_RIGHT, DIR_LEFT};
  logic [7:0] tbl_e [NREQ] = '{8'hC0, 8'h3C, 8'h87, 8'h96};

  rot_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got id=%0d data=%0h expected none", out_id, out_data);
      end else begin
        logic [IDW+ROT_W-1:0] e;
        e = exp_q.pop_front();
        chk("out_id", 32'(out_id), 32'(e[IDW+ROT_W-1:ROT_W]));
        chk("out_data", 32'(out_data), 32'(e[ROT_W-1:0]));
      end
    end
  end

  task automatic clear_reqs();
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    req_dir   = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input logic r);
    req_valid[i]       = 1'b1;
    req_data[8*i +: 8] = d;
    req_amt[3*i +: 3]  = a;
    req_dir[i]         = r;
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  // Check the grant mid-cycle, then advance to just after the next edge.
  task automatic cycle(input string name, input logic [NREQ-1:0] exp_ready);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requests asserted: grants must stay low.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clear_reqs();
    req_valid = '1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_reqs();

    // Idle: nothing granted, pointer parked at 0.
    repeat (10) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_req_ready", 32'(req_ready), 32'd0);
      chk("idle_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
      @(posedge clk); #1;
    end

    // Single requester, right then left rotation of the same byte.
    out_ready = 1'b1;
    set_req(0, 8'hB4, 3'd3, DIR_RIGHT); push_exp(2'd0, 8'h96);
    cycle("t2_right_ready", 4'b0001);
    set_req(0, 8'hB4, 3'd3, DIR_LEFT);  push_exp(2'd0, 8'hA5);
    cycle("t2_left_ready", 4'b0001);
    clear_reqs();
    cycle("t2_idle_ready", 4'b0000);

    // Pointer is at 1; one grant to requester 3 wraps it back to 0.
    set_req(3, tbl_d[3], tbl_a[3], tbl_r[3]); push_exp(2'd3, tbl_e[3]);
    cycle("t3_wrap_ready", 4'b1000);

    // All requesters valid: strict rotation 0,1,2,3,0,1,2,3 at full rate.
    for (int i = 0; i < NREQ; i++) set_req(i, tbl_d[i], tbl_a[i], tbl_r[i]);
    for (int n = 0; n < 8; n++) begin
      push_exp(IDW'(n % NREQ), tbl_e[n % NREQ]);
      cycle("t3_rr_ready", 4'(1 << (n % NREQ)));
    end
    clear_reqs();
    cycle("t3_idle_ready", 4'b0000);

    // Backpressure: grant req1, then stall five cycles with req2/3 waiting.
    out_ready = 1'b0;
    for (int i = 1; i < NREQ; i++) set_req(i, tbl_d[i], tbl_a[i], tbl_r[i]);
    push_exp(2'd1, tbl_e[1]);
    cycle("t4_first_ready", 4'b0010);
    req_valid[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_data", 32'(out_data), 32'h3C);
      chk("t4_stall_id", 32'(out_id), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_exp(2'd2, tbl_e[2]);
    cycle("t4_refill_ready", 4'b0100);
    clear_reqs();
    cycle("t4_idle_ready", 4'b0000);

    // Rotate boundaries on requester 0 (pointer at 3, wraps to 0).
    clear_reqs(); set_req(0, 8'hA7, 3'd0, DIR_RIGHT); push_exp(2'd0, 8'hA7);
    cycle("t5_amt0_r", 4'b0001);
    clear_reqs(); set_req(0, 8'hA7, 3'd0, DIR_LEFT);  push_exp(2'd0, 8'hA7);
    cycle("t5_amt0_l", 4'b0001);
    clear_reqs(); set_req(0, 8'h01, 3'd7, DIR_LEFT);  push_exp(2'd0, 8'h80);
    cycle("t5_amt7_l", 4'b0001);
    clear_reqs(); set_req(0, 8'h3C, 3'd4, DIR_RIGHT); push_exp(2'd0, 8'hC3);
    cycle("t5_amt4_r", 4'b0001);
    clear_reqs(); set_req(0, 8'h3C, 3'd4, DIR_LEFT);  push_exp(2'd0, 8'hC3);
    cycle("t5_amt4_l", 4'b0001);
    clear_reqs();
    cycle("t5_idle_ready", 4'b0000);

    // Reset while a result is held and requester 3 is pending.
    out_ready = 1'b0;
    set_req(2, tbl_d[0], tbl_a[0], tbl_r[0]); push_exp(2'd2, tbl_e[0]);
    cycle("t6_grant_ready", 4'b0100);
    clear_reqs();
    set_req(3, tbl_d[3], tbl_a[3], tbl_r[3]);
    @(negedge clk);
    chk("t6_held_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_data", 32'(out_data), 32'd0);
    chk("t6_async_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, tbl_d[i], tbl_a[i], tbl_r[i]);
    push_exp(2'd0, tbl_e[0]);
    cycle("t6_restart_ready", 4'b0001);
    clear_reqs();
    cycle("t6_idle_ready", 4'b0000);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rot_share_arbiter
`default_nettype wire
